cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

- Producer end of the common data bus (CDB) consumed by the register bank and reservation stations.
- Accepts results from two ALUs through valid/ready handshakes and buffers each ALU in its own FIFO.
- Grants one result per cycle and drives the registered 16-bit CDB word:
  - destination one-hot in bits [15:13];
  - RS slot in bits [12:11];
  - ALU id in bit [10];
  - data in bits [9:0].

## Interface
Parameters:
- DEPTH, 2, entries per ALU FIFO; power of two, 2..8.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- alu0_valid  in  1  ALU0 result present.
- alu0_ready  out  1  ALU0 FIFO can accept; equals (count0 < DEPTH).
- alu0_dest  in  2  destination: 0=R0, 1=R1, 2=R2, 3=no register write.
- alu0_slot  in  2  RS slot of the producing instruction.
- alu0_data  in  10  result value.
- alu1_valid, alu1_ready, alu1_dest, alu1_slot, alu1_data: same as ALU0, for ALU1.
- cdb  out  16  broadcast word (layout above).
- cdb_valid  out  1  cdb carries a result this cycle.

## Operation
- Push: `aluN_valid & aluN_ready` at a rising edge writes {dest, slot, data} at the FIFO tail.
- Ready rule:
  - `aluN_ready` depends only on the registered count.
  - A full FIFO refuses a push even in a cycle where it pops.
- Grant, evaluated from the FIFO heads before each edge:
  - Neither FIFO non-empty: no grant.
  - Exactly one non-empty: grant that FIFO.
  - Both non-empty: grant the ALU other than `last_grant`, then update `last_grant`.
- `last_grant` resets to ALU1, so ALU0 wins the first tie.
- On grant, at the edge:
  - pop the head;
  - register the CDB word;
  - set `cdb_valid=1`.
- CDB word encoding:
  - bit15 = (dest==0), bit14 = (dest==1), bit13 = (dest==2);
  - [12:11] = slot; [10] = ALU id (0/1); [9:0] = data.
- dest=3 broadcasts with [15:13]=000: RS wakeup only, no register write.
- No grant at an edge: `cdb` = 16'h0000 and `cdb_valid` = 0. An all-zero word never writes a register.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- A push into an empty FIFO is not grantable in the same cycle.
- Counts and pointers wrap modulo DEPTH and never overflow or underflow.
- Reset asserted mid-operation:
  - Both FIFOs are emptied and counts set to 0.
  - `cdb` = 0, `cdb_valid` = 0, `last_grant` = ALU1.
  - Buffered results are discarded.
- Reset values of outputs:
  - cdb = 16'h0000, cdb_valid = 0.
  - alu0_ready = alu1_ready = 1 after reset is released; both are 0 while reset is low.

## Timing
- Latency: a result accepted at edge E appears on `cdb` after edge E+1 at the earliest. It is held for exactly one cycle.
- Throughput: one CDB word per cycle.
- Sustained contention: each ALU gets every other cycle. An ALU with a non-empty FIFO waits at most 1 cycle under round-robin.
- Outputs are registered. There is no combinational path from `aluN_*` to `cdb`.
- `aluN_ready` is registered-count based, with no combinational path from `aluN_valid`.
- Reset release is synchronous to the first rising edge after `reset` goes high. Deassertion must meet recovery time.

## Configuration
- CDB_FIXED_PRIORITY_EN
  - Defined: ALU0 always wins when both FIFOs are non-empty. `last_grant` is not implemented. ALU1 may starve.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Reset, then ALU0 pushes dest=1, slot=2, data=37 -> next cycle `cdb`=16'h5025 with `cdb_valid`=1; the following cycle `cdb`=16'h0000.
- After reset, same-edge push of ALU0 (dest=0, slot=0, data=5) and ALU1 (dest=2, slot=3, data=10) -> `cdb`=16'h8005 then 16'h3C0A on consecutive cycles. With CDB_FIXED_PRIORITY_EN the order is the same.
- Both ALUs held valid for 8 cycles with DEPTH=2:
  - Round-robin: ALU ids on `cdb[10]` alternate 0,1,0,1...
  - Fixed priority: all ALU0 while its FIFO is non-empty, and alu1_ready drops to 0 after 2 pushes.
- ALU0 pushes 3 results with no competition and DEPTH=2 -> alu0_ready stays 1 because of pops. Words emerge in push order, with no loss or duplication.
- dest=3, slot=1, data=1023 from ALU1 -> `cdb`=16'h0FFF with `cdb_valid`=1; bits [15:13]=000.
- Assert reset while both FIFOs are full -> `cdb`=0 and `cdb_valid`=0 immediately. After release no stale word is broadcast and both readies are 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB producer: two per-ALU result FIFOs, one grant per cycle, registered 16-bit broadcast word.
// Optional macro CDB_FIXED_PRIORITY_EN makes ALU0 always win ties (default: round-robin).
module cdb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu0_valid,
    output logic        alu0_ready,
    input  logic [1:0]  alu0_dest,
    input  logic [1:0]  alu0_slot,
    input  logic [9:0]  alu0_data,
    input  logic        alu1_valid,
    output logic        alu1_ready,
    input  logic [1:0]  alu1_dest,
    input  logic [1:0]  alu1_slot,
    input  logic [9:0]  alu1_data,
    output logic [15:0] cdb,
    output logic        cdb_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [13:0]   mem [2][DEPTH];
    logic [AW-1:0] wr_ptr [2];
    logic [AW-1:0] rd_ptr [2];
    logic [CW-1:0] count [2];
    logic          running;

    logic [1:0]    valid_v;
    logic [1:0]    ready_v;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    nonempty;
    logic [13:0]   in_word [2];
    logic [13:0]   head [2];
    logic [13:0]   sel;
    logic [2:0]    onehot;
    logic [15:0]   word;

    assign valid_v    = {alu1_valid, alu0_valid};
    assign in_word[0] = {alu0_dest, alu0_slot, alu0_data};
    assign in_word[1] = {alu1_dest, alu1_slot, alu1_data};
    assign alu0_ready = ready_v[0];
    assign alu1_ready = ready_v[1];

    // Ready stays low until the first edge after reset release.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (count[i] != '0);
            ready_v[i]  = running && (count[i] < CW'(DEPTH));
            head[i]     = mem[i][rd_ptr[i]];
        end
    end

    assign push = valid_v & ready_v;

`ifdef CDB_FIXED_PRIORITY_EN
    always_comb begin
        pop = 2'b00;
        if (nonempty[0])
            pop = 2'b01;
        else if (nonempty[1])
            pop = 2'b10;
    end
`else
    logic last_grant;

    always_comb begin
        pop = nonempty;
        if (&nonempty)
            pop = last_grant ? 2'b01 : 2'b10;
    end

    // Only a contested grant moves the round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            last_grant <= 1'b1;
        else if (&nonempty)
            last_grant <= pop[1];
    end
`endif

    always_comb begin
        sel = head[0];
        if (pop[1])
            sel = head[1];
        onehot = 3'b000;
        case (sel[13:12])
            2'd0:    onehot = 3'b100;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b001;
            default: onehot = 3'b000;
        endcase
        word = {onehot, sel[11:10], pop[1], sel[9:0]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running   <= 1'b0;
            cdb       <= 16'h0000;
            cdb_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                for (int j = 0; j < DEPTH; j++)
                    mem[i][j] <= '0;
            end
        end else begin
            running   <= 1'b1;
            cdb       <= (|pop) ? word : 16'h0000;
            cdb_valid <= |pop;
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_word[i];
                    wr_ptr[i]         <= wr_ptr[i] + AW'(1);
                end
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed literal checks.
module tb_cdb_arbiter;

    localparam int D = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        alu0_valid = 1'b0, alu1_valid = 1'b0;
    logic [1:0]  alu0_dest = '0, alu0_slot = '0, alu1_dest = '0, alu1_slot = '0;
    logic [9:0]  alu0_data = '0, alu1_data = '0;
    logic        alu0_ready, alu1_ready, cdb_valid;
    logic [15:0] cdb;

    int errors = 0;
    int checks = 0;

    logic [13:0] q0[$];
    logic [13:0] q1[$];
    bit          m_last = 1'b1;
    bit          m_run  = 1'b0;
    logic [15:0] e_cdb  = '0;
    logic        e_val  = 1'b0;

    cdb_arbiter #(.DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .alu0_valid(alu0_valid), .alu0_ready(alu0_ready), .alu0_dest(alu0_dest),
        .alu0_slot(alu0_slot), .alu0_data(alu0_data),
        .alu1_valid(alu1_valid), .alu1_ready(alu1_ready), .alu1_dest(alu1_dest),
        .alu1_slot(alu1_slot), .alu1_data(alu1_data),
        .cdb(cdb), .cdb_valid(cdb_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [13:0] e, input bit id);
        logic [2:0] oh;
        oh = (e[13:12] == 2'd3) ? 3'b000 : (3'b100 >> e[13:12]);
        return {oh, e[11:10], id, e[9:0]};
    endfunction

    // Drive one cycle of inputs, advance the model, cross the edge, compare.
    task automatic step(input logic v0, input logic [1:0] d0, input logic [1:0] s0, input logic [9:0] x0,
                        input logic v1, input logic [1:0] d1, input logic [1:0] s1, input logic [9:0] x1);
        int n0, n1, g;
        alu0_valid = v0; alu0_dest = d0; alu0_slot = s0; alu0_data = x0;
        alu1_valid = v1; alu1_dest = d1; alu1_slot = s1; alu1_data = x1;
        n0 = q0.size();
        n1 = q1.size();
        g = -1;
        if (n0 > 0 && n1 > 0) begin
`ifdef CDB_FIXED_PRIORITY_EN
            g = 0;
`else
            g = m_last ? 0 : 1;
            m_last = (g == 1);
`endif
        end else if (n0 > 0) g = 0;
        else if (n1 > 0) g = 1;
        if (g == 0) begin e_cdb = enc(q0.pop_front(), 1'b0); e_val = 1'b1; end
        else if (g == 1) begin e_cdb = enc(q1.pop_front(), 1'b1); e_val = 1'b1; end
        else begin e_cdb = 16'h0000; e_val = 1'b0; end
        if (v0 && m_run && n0 < D) q0.push_back({d0, s0, x0});
        if (v1 && m_run && n1 < D) q1.push_back({d1, s1, x1});
        m_run = 1'b1;
        @(posedge clock);
        #1;
        chk("cdb", cdb, e_cdb);
        chk("cdb_valid", 16'(cdb_valid), 16'(e_val));
        chk("alu0_ready", 16'(alu0_ready), 16'(q0.size() < D));
        chk("alu1_ready", 16'(alu1_ready), 16'(q1.size() < D));
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 2'd0, 10'd0, 1'b0, 2'd0, 2'd0, 10'd0);
    endtask

    task automatic do_reset();
        alu0_valid = 1'b0;
        alu1_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk("rst_cdb", cdb, 16'h0000);
        chk("rst_valid", 16'(cdb_valid), 16'h0000);
        chk("rst_ready", {14'd0, alu1_ready, alu0_ready}, 16'h0000);
        q0.delete();
        q1.delete();
        m_last = 1'b1;
        m_run = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();
        idle();
        chk("ready_after_release", {14'd0, alu1_ready, alu0_ready}, 16'h0003);

        // Single push: broadcast two edges later for one cycle.
        step(1'b1, 2'd1, 2'd2, 10'd37, 1'b0, 2'd0, 2'd0, 10'd0);
        chk("no_same_cycle_grant", cdb, 16'h0000);
        idle();
        chk("single_word", cdb, 16'h5025);
        idle();
        chk("single_held_one", cdb, 16'h0000);

        // Simultaneous pushes after reset.
        do_reset();
        idle();
        step(1'b1, 2'd0, 2'd0, 10'd5, 1'b1, 2'd2, 2'd3, 10'd10);
        idle();
        chk("tie_first", cdb, 16'h8005);
        idle();
        chk("tie_second", cdb, 16'h3C0A);

        // Sustained contention for 8 cycles.
        do_reset();
        idle();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 2'($urandom), 2'($urandom), 10'($urandom),
                 1'b1, 2'($urandom), 2'($urandom), 10'($urandom));
`ifdef CDB_FIXED_PRIORITY_EN
            if (k >= 2) chk("fixed_id", 16'(cdb[10]), 16'h0000);
            if (k >= 2) chk("fixed_alu1_ready", 16'(alu1_ready), 16'h0000);
`else
            if (k >= 2) chk("rr_id", 16'(cdb[10]), 16'((k % 2 == 0) ? 0 : 1));
`endif
        end

        // FIFOs loaded, reset mid-operation, nothing stale afterwards.
        do_reset();
        idle();
        chk("post_reset_ready", {14'd0, alu1_ready, alu0_ready}, 16'h0003);
        idle();
        chk("no_stale", {cdb[15:1], cdb_valid}, 16'h0000);

        // Three uncontested ALU0 pushes.
        step(1'b1, 2'd0, 2'd1, 10'd100, 1'b0, 2'd0, 2'd0, 10'd0);
        step(1'b1, 2'd1, 2'd2, 10'd200, 1'b0, 2'd0, 2'd0, 10'd0);
        chk("stream_w1", cdb, 16'h8864);
        step(1'b1, 2'd2, 2'd3, 10'd300, 1'b0, 2'd0, 2'd0, 10'd0);
        chk("stream_w2", cdb, 16'h50C8);
        idle();
        chk("stream_w3", cdb, 16'h392C);
        idle();

        // dest=3 wakeup-only broadcast.
        step(1'b0, 2'd0, 2'd0, 10'd0, 1'b1, 2'd3, 2'd1, 10'd1023);
        idle();
        chk("dest3_word", cdb, 16'h0FFF);
        chk("dest3_valid", 16'(cdb_valid), 16'h0001);
        idle();

        // Randomized traffic with occasional mid-operation reset.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 120) == 0) begin
                do_reset();
                idle();
            end
            step($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 10'($urandom),
                 $urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 10'($urandom));
        end
        repeat (4) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
